// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter: round-robin drain of N_CH FWFT FIFOs into one valid/ready stream.
// Each grant pops at most MAX_BURST words; M_TUSER tags the source channel.
// Optional build macro: FIFO_ARB_STALL_CNT_EN adds a saturating 32-bit STALL_COUNT output.
module fifo_drain_arbiter #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned MAX_BURST = 8,
  localparam int unsigned CH_BITS  = $clog2(N_CH),
  localparam int unsigned CNT_BITS = $clog2(MAX_BURST + 1)
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    ENABLE,
  input  logic [N_CH*WIDTH-1:0]   FIFO_DOUT,
  input  logic [N_CH-1:0]         FIFO_NOT_EMPTY,
  output logic [N_CH-1:0]         FIFO_RE,
  output logic [WIDTH-1:0]        M_TDATA,
  output logic [CH_BITS-1:0]      M_TUSER,
  output logic                    M_TVALID,
  input  logic                    M_TREADY,
  output logic                    BUSY
`ifdef FIFO_ARB_STALL_CNT_EN
  ,
  output logic [31:0]             STALL_COUNT
`endif
);

  typedef enum logic [0:0] {StIdle, StBurst} state_t;

  state_t              r_state, w_state_d;
  logic [CH_BITS-1:0]  r_grant, w_grant_d;
  logic [CH_BITS-1:0]  r_last, w_last_d;
  logic [CNT_BITS-1:0] r_cnt, w_cnt_d;
  logic [WIDTH-1:0]    r_tdata, w_tdata_d;
  logic [CH_BITS-1:0]  r_tuser, w_tuser_d;
  logic                r_tvalid, w_tvalid_d;

  logic [CH_BITS-1:0]  w_rr_sel;
  logic                w_rr_found;
  logic [WIDTH-1:0]    w_dout_sel;
  logic                w_ne_grant;
  logic                w_load_en;
  logic                w_pop;

  // Round-robin search: first non-empty channel starting just after the last grant.
  always_comb begin : rr_search
    int unsigned idx;
    w_rr_sel   = '0;
    w_rr_found = 1'b0;
    idx        = 0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      idx = (32'(r_last) + i) % N_CH;
      if (!w_rr_found && FIFO_NOT_EMPTY[CH_BITS'(idx)]) begin
        w_rr_found = 1'b1;
        w_rr_sel   = CH_BITS'(idx);
      end
    end
  end

  // Select the granted channel's data word and not-empty flag.
  always_comb begin
    w_dout_sel = '0;
    w_ne_grant = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (r_grant == CH_BITS'(k)) begin
        w_dout_sel = FIFO_DOUT[k*WIDTH +: WIDTH];
        w_ne_grant = FIFO_NOT_EMPTY[k];
      end
    end
  end

  assign w_load_en = !r_tvalid || M_TREADY;
  // Reset suppresses the pop so no FIFO word is lost in the reset cycle.
  assign w_pop     = (r_state == StBurst) && w_load_en && w_ne_grant && !RESET;

  // Pop strobe goes only to the granted channel.
  always_comb begin
    FIFO_RE = '0;
    for (int k = 0; k < N_CH; k++) begin
      FIFO_RE[k] = w_pop && (r_grant == CH_BITS'(k));
    end
  end

  // Next-state logic for the grant FSM and burst counter.
  always_comb begin
    w_state_d = r_state;
    w_grant_d = r_grant;
    w_last_d  = r_last;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (ENABLE && w_rr_found) begin
          w_state_d = StBurst;
          w_grant_d = w_rr_sel;
          w_last_d  = w_rr_sel;
          w_cnt_d   = '0;
        end
      end
      StBurst: begin
        if (!w_ne_grant) begin
          // Registered empty flag: seen one cycle after the final pop.
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end else if (w_pop) begin
          if (r_cnt == CNT_BITS'(MAX_BURST - 1)) begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Next-state logic for the output register.
  always_comb begin
    w_tdata_d  = r_tdata;
    w_tuser_d  = r_tuser;
    w_tvalid_d = r_tvalid;
    if (w_pop) begin
      w_tdata_d  = w_dout_sel;
      w_tuser_d  = r_grant;
      w_tvalid_d = 1'b1;
    end else if (w_load_en) begin
      w_tvalid_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= StIdle;
      r_grant  <= '0;
      r_last   <= CH_BITS'(N_CH - 1);
      r_cnt    <= '0;
      r_tdata  <= '0;
      r_tuser  <= '0;
      r_tvalid <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_grant  <= w_grant_d;
      r_last   <= w_last_d;
      r_cnt    <= w_cnt_d;
      r_tdata  <= w_tdata_d;
      r_tuser  <= w_tuser_d;
      r_tvalid <= w_tvalid_d;
    end
  end

  assign M_TDATA  = r_tdata;
  assign M_TUSER  = r_tuser;
  assign M_TVALID = r_tvalid;
  assign BUSY     = (r_state == StBurst) || r_tvalid;

`ifdef FIFO_ARB_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of cycles the output word is held by back-pressure.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_stall_cnt <= '0;
    end else if (r_tvalid && !M_TREADY && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign STALL_COUNT = r_stall_cnt;
`endif

endmodule
